// File: rtl/oam_dma_t.sv
// OAM DMA controller and CPU/DMA memory-bus arbiter.
// Passes CPU accesses through when idle; copies a 256-byte page to the OAM data port when triggered.
module oam_dma_t #(
  parameter logic [15:0] DMA_TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [15:0] cpu_mem_addr_i,
  input  logic        cpu_mem_we_i,
  input  logic [7:0]  cpu_mem_wdata_i,
  input  logic [7:0]  mem_rdata_i,
  output logic [15:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [7:0]  mem_wdata_o,
  output logic        cpu_stall_o,
  output logic        dma_busy_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       par_q;
  logic [7:0] page_q;
  logic [7:0] cnt_q;
  logic [7:0] data_q;
  logic       trig;

  // Only a write seen while idle can start a transfer; retriggers mid-copy are dropped.
  assign trig = (state_q == IDLE) && cpu_mem_we_i && (cpu_mem_addr_i == DMA_TRIG_ADDR);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      par_q   <= 1'b0;
      page_q  <= 8'h00;
      cnt_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      par_q   <= ~par_q;
      if (trig) begin
        page_q <= cpu_mem_wdata_i;
        cnt_q  <= 8'h00;
      end
      if (state_q == READ) begin
        data_q <= mem_rdata_i;
      end
      if (state_q == WRITE) begin
        cnt_q <= cnt_q + 8'h01;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_o  = cpu_mem_addr_i;
    mem_we_o    = cpu_mem_we_i;
    mem_wdata_o = cpu_mem_wdata_i;
    case (state_q)
      IDLE: begin
        if (trig) state_d = HALT;
      end
      HALT: begin
        mem_we_o    = 1'b0;
        mem_wdata_o = 8'h00;
        // A put cycle now means the next cycle is a get cycle, so no alignment slot is needed.
        state_d     = par_q ? READ : ALIGN;
      end
      ALIGN: begin
        mem_we_o    = 1'b0;
        mem_wdata_o = 8'h00;
        state_d     = READ;
      end
      READ: begin
        mem_addr_o  = {page_q, cnt_q};
        mem_we_o    = 1'b0;
        mem_wdata_o = 8'h00;
        state_d     = WRITE;
      end
      WRITE: begin
        mem_addr_o  = OAM_DATA_ADDR;
        mem_we_o    = 1'b1;
        mem_wdata_o = data_q;
        state_d     = (cnt_q == 8'hFF) ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dma_busy_o  = (state_q != IDLE);
  assign cpu_stall_o = dma_busy_o;

endmodule

// File: tb/tb_oam_dma_t.sv
// Bench for oam_dma_t: random CPU traffic against a cycle-timeline model of each DMA transfer.
module tb_oam_dma_t;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [15:0] cpu_mem_addr_i;
  logic        cpu_mem_we_i;
  logic [7:0]  cpu_mem_wdata_i;
  logic [7:0]  mem_rdata_i;
  logic [15:0] mem_addr_o;
  logic        mem_we_o;
  logic [7:0]  mem_wdata_o;
  logic        cpu_stall_o;
  logic        dma_busy_o;

  oam_dma_t dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .cpu_mem_addr_i  (cpu_mem_addr_i),
    .cpu_mem_we_i    (cpu_mem_we_i),
    .cpu_mem_wdata_i (cpu_mem_wdata_i),
    .mem_rdata_i     (mem_rdata_i),
    .mem_addr_o      (mem_addr_o),
    .mem_we_o        (mem_we_o),
    .mem_wdata_o     (mem_wdata_o),
    .cpu_stall_o     (cpu_stall_o),
    .dma_busy_o      (dma_busy_o)
  );

  // clock / reset-relative cycle count (bit 0 is the get/put parity of the current cycle)
  always #5 clk_i = ~clk_i;

  int unsigned cyc;
  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  logic [7:0] mem [65536];
  assign mem_rdata_i = mem[mem_addr_o];

  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] full_obs();
    return {5'b0, dma_busy_o, cpu_stall_o, mem_we_o, mem_addr_o, mem_wdata_o};
  endfunction

  function automatic logic [31:0] ctl_obs();
    return {13'b0, dma_busy_o, cpu_stall_o, mem_we_o, mem_addr_o};
  endfunction

  function automatic logic [31:0] pt_exp();
    return {5'b0, 1'b0, 1'b0, cpu_mem_we_i, cpu_mem_addr_i, cpu_mem_wdata_i};
  endfunction

  // driver tasks
  task automatic drive_idle();
    cpu_mem_addr_i  = 16'($urandom_range(0, 16'hFFFF));
    if (cpu_mem_addr_i == 16'h4014) cpu_mem_addr_i = 16'h4015;
    cpu_mem_we_i    = 1'($urandom_range(0, 1));
    cpu_mem_wdata_i = 8'($urandom_range(0, 255));
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      drive_idle();
      #1 check("pass", full_obs(), pt_exp());
    end
  endtask

  // Spin until the next cycle's trigger would put parity h into the HALT cycle.
  task automatic align(input bit h);
    while (cyc[0] != h) idle_cycles(1);
  endtask

  task automatic trigger(input logic [7:0] p, output bit h);
    logic [15:0] a;
    @(negedge clk_i);
    cpu_mem_addr_i  = 16'h4014;
    cpu_mem_we_i    = 1'b1;
    cpu_mem_wdata_i = p;
    h = ~cyc[0];
    #1 check("trig", full_obs(), pt_exp());
    for (int i = 0; i < 256; i++) begin
      a = {p, 8'(i)};
      exp_q.push_back(mem[a]);
    end
  endtask

  // Timeline model: HALT (+ALIGN when HALT is a get cycle), then 256 read/write pairs.
  task automatic body(input logic [7:0] p, input bit h, input int retrig_k, input int reset_w);
    int len, off, j, i;
    logic [7:0] e;
    len = h ? 513 : 514;
    off = h ? 2 : 3;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk_i);
      cpu_mem_addr_i  = 16'($urandom_range(0, 16'hFFFF));
      cpu_mem_we_i    = 1'($urandom_range(0, 1));
      cpu_mem_wdata_i = 8'($urandom_range(0, 255));
      if (k == retrig_k) begin
        cpu_mem_addr_i  = 16'h4014;
        cpu_mem_we_i    = 1'b1;
        cpu_mem_wdata_i = 8'h07;
      end
      #1;
      if (k < off) begin
        check("hold", full_obs(), {5'b0, 1'b1, 1'b1, 1'b0, cpu_mem_addr_i, 8'h00});
      end else begin
        j = k - off;
        i = j / 2;
        if (j % 2 == 0) begin
          check("rd", ctl_obs(), {13'b0, 1'b1, 1'b1, 1'b0, p, 8'(i)});
        end else begin
          check("wr", ctl_obs(), {13'b0, 1'b1, 1'b1, 1'b1, 16'h2004});
          e = exp_q.pop_front();
          check("wdat", {24'b0, mem_wdata_o}, {24'b0, e});
          if (i == reset_w) begin
            #2 rstn_i = 1'b0;
            #1 check("rst", full_obs(), pt_exp());
            exp_q.delete();
            return;
          end
        end
      end
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    bit h;
    logic [7:0] p;
    rstn_i          = 1'b0;
    cpu_mem_addr_i  = 16'h0000;
    cpu_mem_we_i    = 1'b0;
    cpu_mem_wdata_i = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'hA5;

    idle_cycles(2);
    #1 rstn_i = 1'b1;

    @(negedge clk_i);
    cpu_mem_addr_i = 16'h8000; cpu_mem_we_i = 1'b0; cpu_mem_wdata_i = 8'h00;
    #1 check("pt_rd", full_obs(), {5'b0, 3'b000, 16'h8000, 8'h00});
    @(negedge clk_i);
    cpu_mem_addr_i = 16'h0200; cpu_mem_we_i = 1'b1; cpu_mem_wdata_i = 8'h5A;
    #1 check("pt_wr", full_obs(), {5'b0, 3'b001, 16'h0200, 8'h5A});
    idle_cycles(10);

    // get-cycle HALT (514 stall cycles) with a retrigger at cycle 100
    align(1'b0);
    trigger(8'h03, h);
    body(8'h03, h, 100, -1);
    idle_cycles(3);

    // put-cycle HALT (513) followed back-to-back by a page FF transfer
    align(1'b1);
    trigger(8'h03, h);
    body(8'h03, h, 0, -1);
    trigger(8'hFF, h);
    body(8'hFF, h, 0, -1);
    idle_cycles(2);

    repeat (3) begin
      align(1'($urandom_range(0, 1)));
      p = 8'($urandom_range(0, 255));
      trigger(p, h);
      body(p, h, 0, -1);
      idle_cycles($urandom_range(1, 5));
    end

    // asynchronous reset during write #40, then a complete transfer
    trigger(8'h03, h);
    body(8'h03, h, 0, 39);
    idle_cycles(2);
    #1 rstn_i = 1'b1;
    idle_cycles(4);
    p = 8'($urandom_range(0, 255));
    trigger(p, h);
    body(p, h, 0, -1);
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/oam_dma_t.md
# oam_dma_t

OAM DMA controller and memory-bus arbiter for the NES CPU. It sits between the CPU core's memory port and the system memory bus. In idle it passes CPU accesses straight through. When the CPU writes the source page number to $4014, it takes ownership of the bus and stalls the CPU. It then copies 256 bytes from page `{page,8'h00}` to the PPU OAM data port $2004, one read/write pair per two cycles, with NES-accurate 513/514-cycle stall timing.

## Interface
Parameters:
- `DMA_TRIG_ADDR`, default 16'h4014: CPU write address that starts a transfer.
- `OAM_DATA_ADDR`, default 16'h2004: destination address for every DMA write.

Ports:
- `clk_i` input 1: the single clock; all state changes on its rising edge.
- `rstn_i` input 1: reset, asynchronous and active-low.
- `cpu_mem_addr_i` input 16: CPU bus address.
- `cpu_mem_we_i` input 1: CPU write enable.
- `cpu_mem_wdata_i` input 8: CPU write data.
- `mem_rdata_i` input 8: read data from the memory bus, valid in the same cycle as the address.
- `mem_addr_o` output 16: memory bus address.
- `mem_we_o` output 1: memory bus write enable.
- `mem_wdata_o` output 8: memory bus write data.
- `cpu_stall_o` output 1: CPU hold; feeds the PC block-PC input and the control FSM.
- `dma_busy_o` output 1: high while in any non-IDLE state.

## Operation
- Free-running parity flop `par_q`: reset value 0, toggles every cycle. A cycle with `par_q`=0 is a "get" cycle; `par_q`=1 is a "put" cycle.
- State machine: IDLE, HALT, ALIGN, READ, WRITE.
- **IDLE**
  - Bus outputs are a combinational passthrough of the CPU inputs.
  - `cpu_stall_o`=0.
  - Trigger condition: `cpu_mem_we_i`=1 and `cpu_mem_addr_i`==DMA_TRIG_ADDR.
  - On trigger: latch `page_q`<=`cpu_mem_wdata_i`, clear `cnt_q`, go to HALT. The trigger write itself still appears on the bus.
- **HALT** (dummy cycle, 1 cycle)
  - Bus outputs: `mem_addr_o`=cpu_mem_addr_i, `mem_we_o`=0, `mem_wdata_o`=0.
  - Next state is READ if `par_q`=1 in HALT (the next cycle is a get cycle); otherwise ALIGN.
- **ALIGN** (1 cycle): same bus drive as HALT; always goes to READ.
- **READ**
  - `mem_addr_o`={page_q,cnt_q}, `mem_we_o`=0.
  - `data_q`<=`mem_rdata_i` at the end of the cycle.
  - Go to WRITE.
- **WRITE**
  - `mem_addr_o`=OAM_DATA_ADDR, `mem_we_o`=1, `mem_wdata_o`=data_q.
  - `cnt_q` increments as 8-bit and wraps.
  - If `cnt_q`==8'hFF: go to IDLE. Otherwise go to READ.
- Addressing: source address is `{page_q,cnt_q}` with no carry into the page. Page 8'hFF reads $FF00–$FFFF.
- Outside IDLE, all CPU inputs are ignored, including further $4014 writes; a retrigger during a transfer has no effect.
- `cpu_stall_o`=`dma_busy_o`= (state != IDLE), decoded from the registered state.
- Reset (asynchronous, any time, including mid-transfer):
  - state=IDLE, `par_q`=0, `cnt_q`=0, `page_q`=0, `data_q`=0.
  - `cpu_stall_o`=0 and `dma_busy_o`=0 immediately; bus outputs revert to passthrough.
  - A partial transfer is abandoned and not resumed.

## Timing
- Trigger at cycle T (IDLE, CPU write visible on the bus). HALT at T+1; stall is high from T+1.
- Transfer length:
  - Even case: READ at T+2, 256 READ/WRITE pairs, last WRITE at T+513. Stall is high for 513 cycles.
  - Odd case: ALIGN at T+2, first READ at T+3, last WRITE at T+514. Stall is high for 514 cycles.
- IDLE resumes the cycle after the last WRITE; `cpu_stall_o` falls on that edge.
- READ cycles always have `par_q`=0; WRITE cycles always have `par_q`=1.
- Back-to-back operation: a trigger in the first IDLE cycle after a transfer starts a new transfer.
- Latency: memory-to-OAM latency is 1 cycle (READ then the immediately following WRITE).

## Test plan
- **Passthrough:** in IDLE, CPU reads $8000 and writes $0200←8'h5A. Required: `mem_addr_o`/`mem_we_o`/`mem_wdata_o` mirror the CPU inputs in the same cycle; stall=0.
- **Even-aligned DMA:**
  - Stimulus: memory $0300+i = i^8'hA5; write 8'h03 to $4014 with `par_q`=0 in HALT.
  - Required: 256 writes to $2004 with data i^8'hA5 in order; stall high for exactly 514 cycles.
  - Repeat with trigger timed so `par_q`=1 in HALT. Required: stall high for exactly 513 cycles, no ALIGN cycle.
- **Page FF:** trigger with 8'hFF. Required: read addresses are $FF00..$FFFF, and the last read is $FFFF with no access to $0000.
- **Retrigger ignored:** write 8'h07 to $4014 at cycle 100 of a page-3 transfer. Required: all sources stay in page $03; total length unchanged.
- **Reset mid-transfer:**
  - Stimulus: assert `rstn_i`=0 asynchronously (off-edge) during WRITE #40.
  - Required: stall and busy drop immediately, bus returns to passthrough, no further $2004 writes.
  - After release, a new trigger runs a full 256-byte transfer.
